// File: rtl/noc_tok_pkg.sv
// Shared definitions for the SoC token NoC OCP-lite initiator side.
package noc_tok_pkg;

  localparam int TOK_ADDR_W = 8;
  localparam int TOK_DATA_W = 8;
  localparam int TOK_CMD_W  = 3;

  // MCmd encoding: zero is IDLE, any other value is a live command.
  localparam logic [TOK_CMD_W-1:0] TOK_CMD_IDLE = 3'b000;

  // Arbiter FSM: ARB looks for work, HOLD owns the shared port until
  // SCmdAccept, IDLE parks the port for the power-idle handshake.
  typedef enum logic [1:0] {
    ARB  = 2'd0,
    HOLD = 2'd1,
    IDLE = 2'd2
  } tok_arb_state_e;

endpackage

// File: rtl/noc_tok_rr_pick.sv
// Combinational round-robin find-first: returns the first requester at or
// after ptr_i (wrapping) whose req_i and mask_i bits are both set.
module noc_tok_rr_pick #(
  parameter int N  = 4,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [GW-1:0] ptr_i,
  output logic          valid_o,
  output logic [GW-1:0] idx_o
);

  logic [N-1:0] eff;
  logic [N-1:0] rot;
  int           pos;

  assign eff = req_i & mask_i;

  // Rotate so ptr_i lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    pos     = 0;
    rot     = N'({eff, eff} >> ptr_i);
    valid_o = |rot;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) pos = k;
    end
    pos = pos + int'(ptr_i);
    if (pos >= N) pos = pos - N;
    idx_o = GW'(pos);
  end

endmodule

// File: rtl/noc_tok_ocpl_arb.sv
// Round-robin arbiter sharing one OCP-lite token initiator port between
// NUM_REQ requesters, with power-idle drain/block handshake.
module noc_tok_ocpl_arb
  import noc_tok_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = TOK_ADDR_W,
  parameter int DATA_W  = TOK_DATA_W,
  parameter int CMD_W   = TOK_CMD_W,
  localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_maddr,
  input  logic [NUM_REQ*CMD_W-1:0]  i_req_mcmd,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_mdata,
  output logic [NUM_REQ-1:0]        o_req_scmdaccept,
  output logic [ADDR_W-1:0]         o_m_maddr,
  output logic [CMD_W-1:0]          o_m_mcmd,
  output logic [DATA_W-1:0]         o_m_mdata,
  input  logic                      i_m_scmdaccept,
  input  logic                      i_idle_req,
  output logic                      o_idle_ack,
  output logic                      o_idle_val,
  output logic [GW-1:0]             o_gnt_id
);

  tok_arb_state_e      state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [CMD_W-1:0]    mcmd_q, mcmd_d;
  logic [DATA_W-1:0]   mdata_q, mdata_d;
  logic                idle_q, idle_d;

  logic [NUM_REQ-1:0]  req_vld;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic [NUM_REQ-1:0]  pick_mask;
  logic [GW-1:0]       pick_ptr;
  logic [GW-1:0]       pick_idx;
  logic [GW-1:0]       ptr_inc;
  logic                pick_vld;
  logic                accept;
  int                  sel;

  // A requester is pending whenever its MCmd is not IDLE.
  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vld[i] = (i_req_mcmd[i*CMD_W +: CMD_W] != CMD_W'(TOK_CMD_IDLE));
    end
  end

  assign gnt_onehot = NUM_REQ'(1) << gnt_q;
  // Accept only counts while a command is actually on the port; reset
  // suppresses it so a dropped in-flight command is never acknowledged.
  assign accept     = (state_q == HOLD) && i_m_scmdaccept && !i_rst;
  assign ptr_inc    = (gnt_q == GW'(NUM_REQ - 1)) ? '0 : gnt_q + GW'(1);

  // In HOLD the next winner is searched from past the current grant, with
  // the current grant masked out since its command is being consumed.
  assign pick_ptr  = (state_q == HOLD) ? ptr_inc : ptr_q;
  assign pick_mask = (state_q == HOLD) ? ~gnt_onehot : '1;

  noc_tok_rr_pick #(
    .N  (NUM_REQ),
    .GW (GW)
  ) u_pick (
    .req_i   (req_vld),
    .mask_i  (pick_mask),
    .ptr_i   (pick_ptr),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign sel = int'(pick_idx);

  // Next-state and datapath for the ARB/HOLD/IDLE controller.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    maddr_d = maddr_q;
    mcmd_d  = mcmd_q;
    mdata_d = mdata_q;
    unique case (state_q)
      ARB: begin
        if (i_idle_req) begin
          state_d = IDLE;
        end else if (pick_vld) begin
          state_d = HOLD;
          gnt_d   = pick_idx;
          maddr_d = i_req_maddr[sel*ADDR_W +: ADDR_W];
          mcmd_d  = i_req_mcmd[sel*CMD_W +: CMD_W];
          mdata_d = i_req_mdata[sel*DATA_W +: DATA_W];
        end
      end
      HOLD: begin
        if (accept) begin
          ptr_d   = ptr_inc;
          maddr_d = '0;
          mcmd_d  = CMD_W'(TOK_CMD_IDLE);
          mdata_d = '0;
          if (i_idle_req) begin
            state_d = IDLE;
          end else if (pick_vld) begin
            gnt_d   = pick_idx;
            maddr_d = i_req_maddr[sel*ADDR_W +: ADDR_W];
            mcmd_d  = i_req_mcmd[sel*CMD_W +: CMD_W];
            mdata_d = i_req_mdata[sel*DATA_W +: DATA_W];
          end else begin
            state_d = ARB;
          end
        end
      end
      IDLE: begin
        if (!i_idle_req) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    idle_d = (state_d == IDLE);
  end

  // State and shared-port registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      gnt_q   <= '0;
      maddr_q <= '0;
      mcmd_q  <= CMD_W'(TOK_CMD_IDLE);
      mdata_q <= '0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      maddr_q <= maddr_d;
      mcmd_q  <= mcmd_d;
      mdata_q <= mdata_d;
      idle_q  <= idle_d;
    end
  end

  assign o_req_scmdaccept = accept ? gnt_onehot : '0;
  assign o_m_maddr        = maddr_q;
  assign o_m_mcmd         = mcmd_q;
  assign o_m_mdata        = mdata_q;
  assign o_idle_ack       = idle_q;
  assign o_idle_val       = idle_q;
  assign o_gnt_id         = gnt_q;

endmodule
